// File: rtl/mips_pkg.sv
// mips_pkg: MIPS opcode/funct encodings, ALU codes, decoder control bundle and the NOP instruction
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_SLLV = 4'd10;
  localparam logic [3:0] ALU_SRLV = 4'd11;
  localparam logic [3:0] ALU_SRAV = 4'd12;
  localparam logic [31:0] NOP = 32'h0000_0000;
  typedef enum logic [1:0] {IMM_SIGN, IMM_ZERO, IMM_LUI, IMM_JUMP} imm_kind_e;
  typedef enum logic [1:0] {DST_RD, DST_RT, DST_RA} dst_kind_e;
  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       jump_reg;
    logic       uses_rt;
    imm_kind_e  imm;
    dst_kind_e  dst;
  } ctrl_t;
endpackage

// File: rtl/control_decoder.sv
// control_decoder: combinational opcode/funct -> control bundle (alu op, ctrl bits, imm/dest kind) plus illegal flag
module control_decoder import mips_pkg::*; (
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output ctrl_t      o_ctrl,
  output logic       o_illegal
);
  always_comb begin
    o_ctrl = '0;
    o_ctrl.alu_op = ALU_ADD;
    o_ctrl.imm = IMM_SIGN;
    o_ctrl.dst = DST_RD;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        o_ctrl.uses_rt = 1'b1;
        o_ctrl.reg_write = 1'b1;
        case (i_funct)
          FN_SLL:  o_ctrl.alu_op = ALU_SLL;
          FN_SRL:  o_ctrl.alu_op = ALU_SRL;
          FN_SRA:  o_ctrl.alu_op = ALU_SRA;
          FN_SLLV: o_ctrl.alu_op = ALU_SLLV;
          FN_SRLV: o_ctrl.alu_op = ALU_SRLV;
          FN_SRAV: o_ctrl.alu_op = ALU_SRAV;
          FN_JR:   begin o_ctrl.jump_reg = 1'b1; o_ctrl.reg_write = 1'b0; end
          FN_JALR: o_ctrl.jump_reg = 1'b1;
          FN_ADDU: o_ctrl.alu_op = ALU_ADD;
          FN_SUBU: o_ctrl.alu_op = ALU_SUB;
          FN_AND:  o_ctrl.alu_op = ALU_AND;
          FN_OR:   o_ctrl.alu_op = ALU_OR;
          FN_XOR:  o_ctrl.alu_op = ALU_XOR;
          FN_NOR:  o_ctrl.alu_op = ALU_NOR;
          FN_SLT:  o_ctrl.alu_op = ALU_SLT;
          default: o_illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin o_ctrl.alu_src = 1'b1; o_ctrl.reg_write = 1'b1; o_ctrl.dst = DST_RT; end
      OP_SLTI: begin o_ctrl.alu_src = 1'b1; o_ctrl.reg_write = 1'b1; o_ctrl.dst = DST_RT; o_ctrl.alu_op = ALU_SLT; end
      OP_ANDI: begin o_ctrl.alu_src = 1'b1; o_ctrl.reg_write = 1'b1; o_ctrl.dst = DST_RT; o_ctrl.alu_op = ALU_AND; o_ctrl.imm = IMM_ZERO; end
      OP_ORI:  begin o_ctrl.alu_src = 1'b1; o_ctrl.reg_write = 1'b1; o_ctrl.dst = DST_RT; o_ctrl.alu_op = ALU_OR; o_ctrl.imm = IMM_ZERO; end
      OP_XORI: begin o_ctrl.alu_src = 1'b1; o_ctrl.reg_write = 1'b1; o_ctrl.dst = DST_RT; o_ctrl.alu_op = ALU_XOR; o_ctrl.imm = IMM_ZERO; end
      OP_LUI:  begin o_ctrl.alu_src = 1'b1; o_ctrl.reg_write = 1'b1; o_ctrl.dst = DST_RT; o_ctrl.imm = IMM_LUI; end
      OP_LW:   begin o_ctrl.alu_src = 1'b1; o_ctrl.reg_write = 1'b1; o_ctrl.dst = DST_RT; o_ctrl.mem_read = 1'b1; o_ctrl.mem_to_reg = 1'b1; end
      OP_SW:   begin o_ctrl.alu_src = 1'b1; o_ctrl.mem_write = 1'b1; o_ctrl.uses_rt = 1'b1; o_ctrl.dst = DST_RT; end
      OP_BEQ, OP_BNE: begin o_ctrl.uses_rt = 1'b1; o_ctrl.alu_op = ALU_SUB; o_ctrl.dst = DST_RT; end
      OP_J:    o_ctrl.imm = IMM_JUMP;
      OP_JAL:  begin o_ctrl.imm = IMM_JUMP; o_ctrl.reg_write = 1'b1; o_ctrl.dst = DST_RA; end
      default: o_illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: MIPS ID stage -- regfile addressing, WB bypass, decode, imm extend, load-use stall, ID/EX register
module decode_stage import mips_pkg::*; #(
  parameter int NB_DATA  = 32,
  parameter int NB_REG   = 5,
  parameter int NB_ALUOP = 4
) (
  input  logic                clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  input  logic [31:0]         i_instruction,
  input  logic [NB_DATA-1:0]  i_pc4,
  input  logic                i_flush,
  output logic [NB_REG-1:0]   o_addres_rs,
  output logic [NB_REG-1:0]   o_addres_rt,
  input  logic [NB_DATA-1:0]  i_data_rs,
  input  logic [NB_DATA-1:0]  i_data_rt,
  input  logic                i_wb_wenable,
  input  logic [NB_REG-1:0]   i_wb_addr,
  input  logic [NB_DATA-1:0]  i_wb_data,
  output logic                o_stall,
  output logic                o_valid,
  output logic [NB_DATA-1:0]  o_pc4,
  output logic [NB_DATA-1:0]  o_data_rs,
  output logic [NB_DATA-1:0]  o_data_rt,
  output logic [NB_DATA-1:0]  o_imm,
  output logic [NB_REG-1:0]   o_rs,
  output logic [NB_REG-1:0]   o_rt,
  output logic [NB_REG-1:0]   o_dest,
  output logic [NB_REG-1:0]   o_shamt,
  output logic [NB_ALUOP-1:0] o_alu_op,
  output logic                o_alu_src,
  output logic                o_reg_write,
  output logic                o_mem_read,
  output logic                o_mem_write,
  output logic                o_mem_to_reg,
  output logic                o_jump_reg
);
  typedef struct packed {
    logic                valid;
    logic [NB_DATA-1:0]  pc4;
    logic [NB_DATA-1:0]  data_rs;
    logic [NB_DATA-1:0]  data_rt;
    logic [NB_DATA-1:0]  imm;
    logic [NB_REG-1:0]   rs;
    logic [NB_REG-1:0]   rt;
    logic [NB_REG-1:0]   dest;
    logic [NB_REG-1:0]   shamt;
    logic [NB_ALUOP-1:0] alu_op;
    logic                alu_src;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic                jump_reg;
  } id_ex_t;
  ctrl_t ctrl;
  logic illegal, hazard, load;
  logic [NB_REG-1:0] rs, rt, rd, dest;
  logic [NB_DATA-1:0] rs_val, rt_val, imm;
  id_ex_t id_ex_d, id_ex_q;
  control_decoder u_dec (
    .i_opcode  (i_instruction[31:26]),
    .i_funct   (i_instruction[5:0]),
    .o_ctrl    (ctrl),
    .o_illegal (illegal)
  );
  assign rs = i_instruction[25:21];
  assign rt = i_instruction[20:16];
  assign rd = i_instruction[15:11];
  assign o_addres_rs = rs;
  assign o_addres_rt = rt;
  // $0 is hardwired; otherwise a same-cycle WB write overrides the stale regfile value
  assign rs_val = (rs == '0) ? '0 : (i_wb_wenable && i_wb_addr == rs) ? i_wb_data : i_data_rs;
  assign rt_val = (rt == '0) ? '0 : (i_wb_wenable && i_wb_addr == rt) ? i_wb_data : i_data_rt;
  assign imm = (ctrl.imm == IMM_ZERO) ? {{(NB_DATA-16){1'b0}}, i_instruction[15:0]} :
               (ctrl.imm == IMM_LUI)  ? {i_instruction[15:0], {(NB_DATA-16){1'b0}}} :
               (ctrl.imm == IMM_JUMP) ? {i_pc4[NB_DATA-1 -: 4], i_instruction[25:0], 2'b00} :
                                        {{(NB_DATA-16){i_instruction[15]}}, i_instruction[15:0]};
  assign dest = (ctrl.dst == DST_RA) ? NB_REG'(31) : (ctrl.dst == DST_RT) ? rt : rd;
  assign hazard = i_valid && o_valid && o_mem_read && o_dest != '0 &&
                  (o_dest == rs || (ctrl.uses_rt && o_dest == rt));
  assign o_stall = hazard && !i_flush;
  assign load = !i_flush && !hazard && i_valid && !illegal;
  always_comb begin
    id_ex_d = '0;
    if (load) begin
      id_ex_d.valid      = 1'b1;
      id_ex_d.pc4        = i_pc4;
      id_ex_d.data_rs    = rs_val;
      id_ex_d.data_rt    = rt_val;
      id_ex_d.imm        = imm;
      id_ex_d.rs         = rs;
      id_ex_d.rt         = rt;
      id_ex_d.dest       = dest;
      id_ex_d.shamt      = i_instruction[10:6];
      id_ex_d.alu_op     = NB_ALUOP'(ctrl.alu_op);
      id_ex_d.alu_src    = ctrl.alu_src;
      id_ex_d.reg_write  = ctrl.reg_write && dest != '0;
      id_ex_d.mem_read   = ctrl.mem_read;
      id_ex_d.mem_write  = ctrl.mem_write;
      id_ex_d.mem_to_reg = ctrl.mem_to_reg;
      id_ex_d.jump_reg   = ctrl.jump_reg;
    end
  end
  always_ff @(posedge clk or negedge i_rst_n)
    if (!i_rst_n) id_ex_q <= '0;
    else id_ex_q <= id_ex_d;
  assign o_valid      = id_ex_q.valid;
  assign o_pc4        = id_ex_q.pc4;
  assign o_data_rs    = id_ex_q.data_rs;
  assign o_data_rt    = id_ex_q.data_rt;
  assign o_imm        = id_ex_q.imm;
  assign o_rs         = id_ex_q.rs;
  assign o_rt         = id_ex_q.rt;
  assign o_dest       = id_ex_q.dest;
  assign o_shamt      = id_ex_q.shamt;
  assign o_alu_op     = id_ex_q.alu_op;
  assign o_alu_src    = id_ex_q.alu_src;
  assign o_reg_write  = id_ex_q.reg_write;
  assign o_mem_read   = id_ex_q.mem_read;
  assign o_mem_write  = id_ex_q.mem_write;
  assign o_mem_to_reg = id_ex_q.mem_to_reg;
  assign o_jump_reg   = id_ex_q.jump_reg;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage
module tb_decode_stage;
  logic clk = 0, rst_n = 0, valid = 0, flush = 0, wb_en = 0;
  logic [31:0] instr = 0, pc4 = 0, d_rs = 0, d_rt = 0, wb_data = 0;
  logic [4:0] wb_addr = 0;
  logic [4:0] a_rs, a_rt, o_rs, o_rt, o_dest, o_shamt;
  logic stall, o_valid, alu_src, reg_write, mem_read, mem_write, mem_to_reg, jump_reg;
  logic [31:0] o_pc4, o_drs, o_drt, o_imm;
  logic [3:0] alu_op;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  decode_stage dut (
    .clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_instruction(instr), .i_pc4(pc4),
    .i_flush(flush), .o_addres_rs(a_rs), .o_addres_rt(a_rt), .i_data_rs(d_rs), .i_data_rt(d_rt),
    .i_wb_wenable(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data), .o_stall(stall),
    .o_valid(o_valid), .o_pc4(o_pc4), .o_data_rs(o_drs), .o_data_rt(o_drt), .o_imm(o_imm),
    .o_rs(o_rs), .o_rt(o_rt), .o_dest(o_dest), .o_shamt(o_shamt), .o_alu_op(alu_op),
    .o_alu_src(alu_src), .o_reg_write(reg_write), .o_mem_read(mem_read), .o_mem_write(mem_write),
    .o_mem_to_reg(mem_to_reg), .o_jump_reg(jump_reg)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] rs_d, input logic [31:0] rt_d);
    valid = v;
    instr = ins;
    d_rs = rs_d;
    d_rt = rt_d;
    #1;
  endtask
  task automatic test_reset;
    drive(1, 32'h2023FFFC, 32'h10, 0);
    tick;
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got %b exp 1", o_valid); end
    #2 rst_n = 0;
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid got %b exp 0", o_valid); end
    checks++; if (o_imm !== 32'h0) begin errors++; $display("FAIL async_reset_imm got %h exp 0", o_imm); end
    checks++; if ({o_dest, reg_write, alu_src, o_drs} !== 38'h0) begin errors++; $display("FAIL async_reset_fields got %h exp 0", {o_dest, reg_write, alu_src, o_drs}); end
    @(negedge clk);
    rst_n = 1;
    drive(0, 32'h2023FFFC, 32'h10, 0);
    tick;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL idle_bubble got %b exp 0", o_valid); end
  endtask
  task automatic test_addi;
    drive(1, 32'h2023FFFC, 32'h10, 32'h99);
    checks++; if ({a_rs, a_rt} !== {5'd1, 5'd3}) begin errors++; $display("FAIL read_addr got %h exp %h", {a_rs, a_rt}, {5'd1, 5'd3}); end
    tick;
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %b exp 1", o_valid); end
    checks++; if (o_imm !== 32'hFFFFFFFC) begin errors++; $display("FAIL addi_imm got %h exp FFFFFFFC", o_imm); end
    checks++; if (o_drs !== 32'h10) begin errors++; $display("FAIL addi_rs got %h exp 10", o_drs); end
    checks++; if (o_dest !== 5'd3) begin errors++; $display("FAIL addi_dest got %0d exp 3", o_dest); end
    checks++; if ({alu_src, reg_write, alu_op} !== {1'b1, 1'b1, 4'd0}) begin errors++; $display("FAIL addi_ctrl got %b exp 110000", {alu_src, reg_write, alu_op}); end
  endtask
  task automatic test_imm;
    drive(1, 32'h34028001, 0, 0);
    tick;
    checks++; if (o_imm !== 32'h00008001) begin errors++; $display("FAIL ori_imm got %h exp 00008001", o_imm); end
    checks++; if (alu_op !== 4'd3) begin errors++; $display("FAIL ori_aluop got %0d exp 3", alu_op); end
    drive(1, 32'h3C02FF01, 0, 0);
    tick;
    checks++; if (o_imm !== 32'hFF010000) begin errors++; $display("FAIL lui_imm got %h exp FF010000", o_imm); end
  endtask
  task automatic test_load_use;
    drive(1, 32'h8C230000, 32'h100, 0);
    tick;
    checks++; if ({o_valid, mem_read, mem_to_reg, o_dest} !== {3'b111, 5'd3}) begin errors++; $display("FAIL lw_ctrl got %b exp 11100011", {o_valid, mem_read, mem_to_reg, o_dest}); end
    drive(1, 32'h00612021, 32'h5, 32'h100);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b exp 1", stall); end
    tick;
    checks++; if ({o_valid, mem_read} !== 2'b00) begin errors++; $display("FAIL lu_bubble got %b exp 00", {o_valid, mem_read}); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_clear got %b exp 0", stall); end
    tick;
    checks++; if ({o_valid, o_dest, alu_op} !== {1'b1, 5'd4, 4'd0}) begin errors++; $display("FAIL lu_issue got %h exp %h", {o_valid, o_dest, alu_op}, {1'b1, 5'd4, 4'd0}); end
    drive(1, 32'h8C200000, 32'h100, 0);
    tick;
    checks++; if ({mem_read, reg_write} !== 2'b10) begin errors++; $display("FAIL lw0_ctrl got %b exp 10", {mem_read, reg_write}); end
    drive(1, 32'h00012021, 0, 0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lw0_nostall got %b exp 0", stall); end
    tick;
  endtask
  task automatic test_rt_hazard_and_flush;
    drive(1, 32'h8C230000, 0, 0);
    tick;
    drive(1, 32'h34A30001, 0, 0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ori_rt_nostall got %b exp 0", stall); end
    drive(1, 32'hAC430000, 0, 0);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sw_rt_stall got %b exp 1", stall); end
    flush = 1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_hazard_stall got %b exp 0", stall); end
    tick;
    checks++; if ({o_valid, mem_read, reg_write} !== 3'b000) begin errors++; $display("FAIL flush_bubble got %b exp 000", {o_valid, mem_read, reg_write}); end
    flush = 0;
  endtask
  task automatic test_bypass;
    wb_en = 1; wb_addr = 5'd1; wb_data = 32'hFF010011;
    drive(1, 32'h00232821, 0, 32'h7);
    tick;
    checks++; if (o_drs !== 32'hFF010011) begin errors++; $display("FAIL bypass_rs got %h exp FF010011", o_drs); end
    checks++; if (o_drt !== 32'h7) begin errors++; $display("FAIL bypass_rt got %h exp 7", o_drt); end
    wb_addr = 5'd0; wb_data = 32'hDEAD;
    drive(1, 32'h00032821, 0, 32'h7);
    tick;
    checks++; if (o_drs !== 32'h0) begin errors++; $display("FAIL bypass_r0 got %h exp 0", o_drs); end
    wb_en = 0;
  endtask
  task automatic test_jumps_illegal;
    drive(1, 32'hFC000000, 0, 0);
    tick;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL illegal_valid got %b exp 0", o_valid); end
    pc4 = 32'h40000008;
    drive(1, 32'h0C000010, 0, 0);
    tick;
    checks++; if ({o_dest, reg_write} !== {5'd31, 1'b1}) begin errors++; $display("FAIL jal_dest got %h exp %h", {o_dest, reg_write}, {5'd31, 1'b1}); end
    checks++; if ({o_imm, o_pc4} !== {32'h40000040, 32'h40000008}) begin errors++; $display("FAIL jal_imm got %h exp 4000004040000008", {o_imm, o_pc4}); end
    drive(1, 32'h03E00008, 32'h1234, 0);
    tick;
    checks++; if ({jump_reg, reg_write, o_valid} !== 3'b101) begin errors++; $display("FAIL jr_ctrl got %b exp 101", {jump_reg, reg_write, o_valid}); end
    checks++; if (o_drs !== 32'h1234) begin errors++; $display("FAIL jr_rs got %h exp 1234", o_drs); end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    test_reset;
    test_addi;
    test_imm;
    test_load_use;
    test_rt_hazard_and_flush;
    test_bypass;
    test_jumps_illegal;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
